// File: rtl/pipe_d_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : pipe_d_scoreboard
// Description : Decode-stage operand resolver.
//               - Picks each source operand from the register file or from a
//                 forwarding path: EX ALU, MEM ALU, MEM load data, or the
//                 long-op completion port.
//               - Generates the decode stall.
//               - Keeps a per-register scoreboard of results still owed by the
//                 multi-cycle unit, which writes back out of order.
// Ports       : clock, resetn        - clock, async active-low reset
//               d_*                  - decoded instruction fields
//               qa, qb               - register file read data
//               e_*, m_*             - EX / MEM stage destination info and data
//               l_done/l_rn/l_result - long-unit completion port
//               da, db, fwda, fwdb   - resolved operands and their source select
//               stall, issue         - decode stall / instruction accepted
//               busy, long_cnt       - scoreboard vector, outstanding long ops
//               stall_cnt, sb_err    - saturating stall count, sticky error
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_d_scoreboard #(
    parameter  int XLEN     = 32,
    parameter  int NREG     = 32,
    parameter  int MAX_LONG = 4,
    parameter  int SCW      = 16,
    localparam int RW       = $clog2(NREG),
    localparam int CW       = $clog2(MAX_LONG + 1)
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            d_valid,
    input  logic            d_flush,
    input  logic [RW-1:0]   d_rs,
    input  logic [RW-1:0]   d_rt,
    input  logic            d_use_rs,
    input  logic            d_use_rt,
    input  logic            d_wreg,
    input  logic [RW-1:0]   d_rn,
    input  logic            d_long,
    input  logic [XLEN-1:0] qa,
    input  logic [XLEN-1:0] qb,
    input  logic            e_wreg,
    input  logic            e_m2reg,
    input  logic [RW-1:0]   e_rn,
    input  logic [XLEN-1:0] e_alu,
    input  logic            m_wreg,
    input  logic            m_m2reg,
    input  logic [RW-1:0]   m_rn,
    input  logic [XLEN-1:0] m_alu,
    input  logic [XLEN-1:0] m_mo,
    input  logic            l_done,
    input  logic [RW-1:0]   l_rn,
    input  logic [XLEN-1:0] l_result,
    output logic [XLEN-1:0] da,
    output logic [XLEN-1:0] db,
    output logic [2:0]      fwda,
    output logic [2:0]      fwdb,
    output logic            stall,
    output logic            issue,
    output logic [NREG-1:0] busy,
    output logic [CW-1:0]   long_cnt,
    output logic [SCW-1:0]  stall_cnt,
    output logic            sb_err
);

    localparam logic [2:0]    c_fwd_rf    = 3'd0;
    localparam logic [2:0]    c_fwd_e     = 3'd1;
    localparam logic [2:0]    c_fwd_m_alu = 3'd2;
    localparam logic [2:0]    c_fwd_m_mo  = 3'd3;
    localparam logic [2:0]    c_fwd_l     = 3'd4;
    localparam logic [CW-1:0] c_max_long  = CW'(MAX_LONG);

    logic [NREG-1:0] r_busy;
    logic [CW-1:0]   r_long_cnt;
    logic [SCW-1:0]  r_stall_cnt;
    logic            r_sb_err;

    logic            w_act;
    logic            w_rs_live;
    logic            w_rt_live;
    logic            w_l_hit_rs;
    logic            w_l_hit_rt;
    logic            w_l_hit_rn;
    logic            w_load_use;
    logic            w_raw_long;
    logic            w_waw;
    logic            w_struct;
    logic            w_stall;
    logic            w_issue;
    logic            w_l_err;
    logic            w_l_ok;
    logic            w_long_issue;
    logic            w_set;
    logic [NREG-1:0] w_busy_nxt;

    // Register 0 is hard-wired: a source of r0 never forwards and never stalls.
    assign w_act     = d_valid & ~d_flush;
    assign w_rs_live = d_use_rs & (d_rs != '0);
    assign w_rt_live = d_use_rt & (d_rt != '0);

    assign w_l_hit_rs = l_done & (l_rn == d_rs);
    assign w_l_hit_rt = l_done & (l_rn == d_rt);
    assign w_l_hit_rn = l_done & (l_rn == d_rn);

    // Operand data selected by forwarding code.
    function automatic logic [XLEN-1:0] operand_mux(
        input logic [2:0]      sel,
        input logic [XLEN-1:0] q,
        input logic [XLEN-1:0] ex_alu,
        input logic [XLEN-1:0] mem_alu,
        input logic [XLEN-1:0] mem_mo,
        input logic [XLEN-1:0] long_res
    );
        case (sel)
            c_fwd_e:     operand_mux = ex_alu;
            c_fwd_m_alu: operand_mux = mem_alu;
            c_fwd_m_mo:  operand_mux = mem_mo;
            c_fwd_l:     operand_mux = long_res;
            default:     operand_mux = q;
        endcase
    endfunction

    // First match wins: youngest producer (EX) before MEM before long unit.
    // A load in EX is not forwardable; that case is covered by the stall.
    always_comb begin
        fwda = c_fwd_rf;
        if (w_rs_live) begin
            if (e_wreg && !e_m2reg && (e_rn == d_rs))
                fwda = c_fwd_e;
            else if (m_wreg && (m_rn == d_rs))
                fwda = m_m2reg ? c_fwd_m_mo : c_fwd_m_alu;
            else if (w_l_hit_rs)
                fwda = c_fwd_l;
        end
    end

    always_comb begin
        fwdb = c_fwd_rf;
        if (w_rt_live) begin
            if (e_wreg && !e_m2reg && (e_rn == d_rt))
                fwdb = c_fwd_e;
            else if (m_wreg && (m_rn == d_rt))
                fwdb = m_m2reg ? c_fwd_m_mo : c_fwd_m_alu;
            else if (w_l_hit_rt)
                fwdb = c_fwd_l;
        end
    end

    assign da = operand_mux(fwda, qa, e_alu, m_alu, m_mo, l_result);
    assign db = operand_mux(fwdb, qb, e_alu, m_alu, m_mo, l_result);

    // A register completing this cycle is no longer a hazard: the consumer
    // takes it through the bypass.
    assign w_load_use = (w_rs_live & e_wreg & e_m2reg & (e_rn == d_rs))
                      | (w_rt_live & e_wreg & e_m2reg & (e_rn == d_rt));
    assign w_raw_long = (w_rs_live & r_busy[d_rs] & ~w_l_hit_rs)
                      | (w_rt_live & r_busy[d_rt] & ~w_l_hit_rt);
    assign w_waw      = d_wreg & r_busy[d_rn] & ~w_l_hit_rn;
    assign w_struct   = d_long & (r_long_cnt == c_max_long);

    assign w_stall = w_act & (w_load_use | w_raw_long | w_waw | w_struct);
    assign w_issue = w_act & ~w_stall;

    // A completion for a register nobody is waiting on is a protocol error.
    // It is flagged and otherwise ignored, so the scoreboard stays consistent.
    assign w_l_err      = l_done & ((l_rn == '0) | ~r_busy[l_rn] | (r_long_cnt == '0));
    assign w_l_ok       = l_done & ~w_l_err;
    assign w_long_issue = w_issue & d_long;
    assign w_set        = w_long_issue & d_wreg & (d_rn != '0);

    // Clear first, then set, so a new issue to a register completing in the
    // same cycle keeps the busy bit.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_l_ok)
            w_busy_nxt[l_rn] = 1'b0;
        if (w_set)
            w_busy_nxt[d_rn] = 1'b1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_busy      <= '0;
            r_long_cnt  <= '0;
            r_stall_cnt <= '0;
            r_sb_err    <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            case ({w_long_issue, w_l_ok})
                2'b10:   r_long_cnt <= r_long_cnt + CW'(1);
                2'b01:   r_long_cnt <= r_long_cnt - CW'(1);
                default: r_long_cnt <= r_long_cnt;
            endcase
            if (w_stall && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + SCW'(1);
            if (w_l_err)
                r_sb_err <= 1'b1;
        end
    end

    assign stall     = w_stall;
    assign issue     = w_issue;
    assign busy      = r_busy;
    assign long_cnt  = r_long_cnt;
    assign stall_cnt = r_stall_cnt;
    assign sb_err    = r_sb_err;

endmodule
`default_nettype wire

// File: tb/tb_pipe_d_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_d_scoreboard
// Description : Self-checking bench for pipe_d_scoreboard.
//               - A driver applies directed then random decode cycles.
//               - For each cycle, a reference model predicts the outputs and
//                 queues them.
//               - The model tracks outstanding long operations as a list of
//                 destinations.
//               - A monitor pops each prediction on the falling edge and
//                 compares it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_d_scoreboard;

    localparam int XLEN     = 32;
    localparam int NREG     = 32;
    localparam int MAX_LONG = 4;
    localparam int SCW      = 16;

    typedef struct {
        logic        resetn, d_valid, d_flush;
        logic [4:0]  d_rs, d_rt;
        logic        use_rs, use_rt, d_wreg;
        logic [4:0]  d_rn;
        logic        d_long;
        logic [31:0] qa, qb;
        logic        e_wreg, e_m2reg;
        logic [4:0]  e_rn;
        logic [31:0] e_alu;
        logic        m_wreg, m_m2reg;
        logic [4:0]  m_rn;
        logic [31:0] m_alu, m_mo;
        logic        l_done;
        logic [4:0]  l_rn;
        logic [31:0] l_result;
    } stim_t;

    typedef struct {
        logic [31:0] da, db;
        logic [2:0]  fwda, fwdb;
        logic        stall, issue;
        logic [31:0] busy;
        logic [2:0]  long_cnt;
        logic [15:0] stall_cnt;
        logic        sb_err;
    } exp_t;

    logic        clock, resetn, d_valid, d_flush, d_use_rs, d_use_rt, d_wreg, d_long;
    logic [4:0]  d_rs, d_rt, d_rn, e_rn, m_rn, l_rn;
    logic [31:0] qa, qb, e_alu, m_alu, m_mo, l_result, da, db;
    logic        e_wreg, e_m2reg, m_wreg, m_m2reg, l_done;
    logic [2:0]  fwda, fwdb, long_cnt;
    logic        stall, issue, sb_err;
    logic [31:0] busy;
    logic [15:0] stall_cnt;

    pipe_d_scoreboard #(
        .XLEN(XLEN), .NREG(NREG), .MAX_LONG(MAX_LONG), .SCW(SCW)
    ) dut (
        .clock(clock), .resetn(resetn), .d_valid(d_valid), .d_flush(d_flush),
        .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
        .d_wreg(d_wreg), .d_rn(d_rn), .d_long(d_long), .qa(qa), .qb(qb),
        .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_rn(e_rn), .e_alu(e_alu),
        .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_rn(m_rn), .m_alu(m_alu), .m_mo(m_mo),
        .l_done(l_done), .l_rn(l_rn), .l_result(l_result),
        .da(da), .db(db), .fwda(fwda), .fwdb(fwdb), .stall(stall), .issue(issue),
        .busy(busy), .long_cnt(long_cnt), .stall_cnt(stall_cnt), .sb_err(sb_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference state: destinations owed by the long unit (-1 = no register).
    int    pending[$];
    int    m_stall_cnt;
    bit    m_err;
    exp_t  exp_q[$];
    int    checks;
    int    failures;

    function automatic bit m_busy(input int r);
        if (r == 0) return 1'b0;
        foreach (pending[i]) if (pending[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        s.resetn = 1'b1;
        return s;
    endfunction

    function automatic bit completes(input stim_t st, input logic [4:0] r);
        return st.l_done && (st.l_rn == r);
    endfunction

    function automatic void src_model(input stim_t st, input logic [4:0] s, input logic use_s,
                                      input logic [31:0] q, output logic [2:0] f,
                                      output logic [31:0] d);
        f = 3'd0;
        d = q;
        if (!use_s || s == 5'd0) return;
        if (st.e_wreg && !st.e_m2reg && st.e_rn == s) begin
            f = 3'd1; d = st.e_alu;
        end else if (st.m_wreg && st.m_rn == s) begin
            if (st.m_m2reg) begin f = 3'd3; d = st.m_mo; end
            else            begin f = 3'd2; d = st.m_alu; end
        end else if (completes(st, s)) begin
            f = 3'd4; d = st.l_result;
        end
    endfunction

    function automatic bit src_hazard(input stim_t st, input logic [4:0] s, input logic use_s);
        if (!use_s || s == 5'd0) return 1'b0;
        if (st.e_wreg && st.e_m2reg && st.e_rn == s) return 1'b1;
        return m_busy(int'(s)) && !completes(st, s);
    endfunction

    task automatic apply(input stim_t s);
        resetn = s.resetn; d_valid = s.d_valid; d_flush = s.d_flush;
        d_rs = s.d_rs; d_rt = s.d_rt; d_use_rs = s.use_rs; d_use_rt = s.use_rt;
        d_wreg = s.d_wreg; d_rn = s.d_rn; d_long = s.d_long; qa = s.qa; qb = s.qb;
        e_wreg = s.e_wreg; e_m2reg = s.e_m2reg; e_rn = s.e_rn; e_alu = s.e_alu;
        m_wreg = s.m_wreg; m_m2reg = s.m_m2reg; m_rn = s.m_rn; m_alu = s.m_alu; m_mo = s.m_mo;
        l_done = s.l_done; l_rn = s.l_rn; l_result = s.l_result;
    endtask

    // One decode cycle: drive, predict, queue the prediction, advance the model.
    task automatic cycle(input stim_t st);
        exp_t e;
        bit   live;
        bit   err;
        int   idx;
        @(posedge clock);
        #2;
        apply(st);
        if (!st.resetn) begin
            pending.delete();
            m_stall_cnt = 0;
            m_err = 1'b0;
        end
        src_model(st, st.d_rs, st.use_rs, st.qa, e.fwda, e.da);
        src_model(st, st.d_rt, st.use_rt, st.qb, e.fwdb, e.db);
        live = st.d_valid && !st.d_flush;
        e.stall = live && (src_hazard(st, st.d_rs, st.use_rs) ||
                           src_hazard(st, st.d_rt, st.use_rt) ||
                           (st.d_wreg && m_busy(int'(st.d_rn)) && !completes(st, st.d_rn)) ||
                           (st.d_long && pending.size() == MAX_LONG));
        e.issue = live && !e.stall;
        for (int r = 0; r < NREG; r++) e.busy[r] = m_busy(r);
        e.long_cnt  = 3'(pending.size());
        e.stall_cnt = 16'(m_stall_cnt);
        e.sb_err    = m_err;
        exp_q.push_back(e);
        if (st.resetn) begin
            err = st.l_done && (st.l_rn == 5'd0 || !m_busy(int'(st.l_rn)) || pending.size() == 0);
            if (st.l_done && !err) begin
                idx = -1;
                foreach (pending[i]) if (idx < 0 && pending[i] == int'(st.l_rn)) idx = i;
                pending.delete(idx);
            end
            if (e.issue && st.d_long)
                pending.push_back((st.d_wreg && st.d_rn != 5'd0) ? int'(st.d_rn) : -1);
            if (err) m_err = 1'b1;
            if (e.stall && m_stall_cnt < 65535) m_stall_cnt++;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: the DUT presents a full output set every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("da",        da,                 e.da);
                chk("db",        db,                 e.db);
                chk("fwda",      32'(fwda),          32'(e.fwda));
                chk("fwdb",      32'(fwdb),          32'(e.fwdb));
                chk("stall",     32'(stall),         32'(e.stall));
                chk("issue",     32'(issue),         32'(e.issue));
                chk("busy",      busy,               e.busy);
                chk("long_cnt",  32'(long_cnt),      32'(e.long_cnt));
                chk("stall_cnt", 32'(stall_cnt),     32'(e.stall_cnt));
                chk("sb_err",    32'(sb_err),        32'(e.sb_err));
            end
        end
    end

    task automatic rand_cycle();
        stim_t s;
        int    cand[$];
        s = idle();
        s.resetn  = ($urandom_range(0, 299) != 0);
        s.d_valid = ($urandom_range(0, 9) != 0);
        s.d_flush = ($urandom_range(0, 15) == 0);
        s.d_rs    = 5'($urandom_range(0, 7));
        s.d_rt    = 5'($urandom_range(0, 7));
        s.use_rs  = 1'($urandom_range(0, 1));
        s.use_rt  = 1'($urandom_range(0, 1));
        s.d_wreg  = ($urandom_range(0, 4) != 0);
        s.d_rn    = 5'($urandom_range(0, 7));
        s.d_long  = ($urandom_range(0, 3) == 0);
        if (s.d_long) begin
            s.d_wreg = 1'b1;
            s.d_rn   = 5'($urandom_range(1, 7));
        end
        s.qa      = $urandom;
        s.qb      = $urandom;
        s.e_wreg  = 1'($urandom_range(0, 1));
        s.e_m2reg = ($urandom_range(0, 2) == 0);
        s.e_rn    = 5'($urandom_range(0, 7));
        s.e_alu   = $urandom;
        s.m_wreg  = 1'($urandom_range(0, 1));
        s.m_m2reg = ($urandom_range(0, 2) == 0);
        s.m_rn    = 5'($urandom_range(0, 7));
        s.m_alu   = $urandom;
        s.m_mo    = $urandom;
        s.l_result = $urandom;
        foreach (pending[i]) if (pending[i] > 0) cand.push_back(pending[i]);
        if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
            s.l_done = 1'b1;
            s.l_rn   = 5'(cand[$urandom_range(0, cand.size() - 1)]);
        end else if ($urandom_range(0, 39) == 0) begin
            s.l_done = 1'b1;
            s.l_rn   = 5'($urandom_range(0, 31));
        end
        cycle(s);
    endtask

    initial begin
        stim_t s;
        checks = 0;
        failures = 0;
        m_stall_cnt = 0;
        m_err = 1'b0;
        s = idle();
        s.resetn = 1'b0;
        apply(s);
        cycle(s);
        cycle(s);

        // EX forwarding has priority over MEM
        s = idle(); s.d_valid = 1; s.d_rs = 5; s.use_rs = 1; s.qa = 32'h99;
        s.e_wreg = 1; s.e_rn = 5; s.e_alu = 32'h11; s.m_wreg = 1; s.m_rn = 5; s.m_alu = 32'h22;
        cycle(s);

        // Load-use: one stall, then the load data comes from MEM
        s = idle(); s.d_valid = 1; s.d_rt = 3; s.use_rt = 1; s.e_wreg = 1; s.e_m2reg = 1; s.e_rn = 3;
        cycle(s);
        s = idle(); s.d_valid = 1; s.d_rt = 3; s.use_rt = 1;
        s.m_wreg = 1; s.m_m2reg = 1; s.m_rn = 3; s.m_mo = 32'hABCD;
        cycle(s);

        // Long RAW on r7: consumer waits until the completion cycle
        s = idle(); s.d_valid = 1; s.d_long = 1; s.d_wreg = 1; s.d_rn = 7;
        cycle(s);
        s = idle(); s.d_valid = 1; s.d_rs = 7; s.use_rs = 1;
        cycle(s);
        cycle(s);
        s.l_done = 1; s.l_rn = 7; s.l_result = 32'h55;
        cycle(s);
        cycle(idle());

        // Structural limit, then simultaneous complete/issue on r1
        for (int i = 1; i <= 4; i++) begin
            s = idle(); s.d_valid = 1; s.d_long = 1; s.d_wreg = 1; s.d_rn = 5'(i);
            cycle(s);
        end
        s = idle(); s.d_valid = 1; s.d_long = 1; s.d_wreg = 1; s.d_rn = 6;
        cycle(s);
        cycle(s);
        s = idle(); s.l_done = 1; s.l_rn = 2; cycle(s);
        s = idle(); s.d_valid = 1; s.d_long = 1; s.d_wreg = 1; s.d_rn = 1; s.l_done = 1; s.l_rn = 1;
        cycle(s);
        s = idle(); s.l_done = 1; s.l_rn = 1; cycle(s);
        s.l_rn = 3; cycle(s);
        s.l_rn = 4; cycle(s);

        // Register 0 never forwards; flush suppresses stall and issue
        s = idle(); s.d_valid = 1; s.d_rs = 0; s.use_rs = 1; s.qa = 32'h1234;
        s.e_wreg = 1; s.e_rn = 0; s.e_alu = 32'hDEAD;
        cycle(s);
        s = idle(); s.d_valid = 1; s.d_long = 1; s.d_wreg = 1; s.d_rn = 8;
        cycle(s);
        s = idle(); s.d_valid = 1; s.d_flush = 1; s.d_rs = 8; s.use_rs = 1;
        s.d_long = 1; s.d_wreg = 1; s.d_rn = 11;
        cycle(s);
        s = idle(); s.l_done = 1; s.l_rn = 8; cycle(s);

        // Completion for a non-busy register; then reset in the middle of a stall
        s = idle(); s.l_done = 1; s.l_rn = 9; cycle(s);
        cycle(idle());
        s = idle(); s.d_valid = 1; s.d_long = 1; s.d_wreg = 1; s.d_rn = 10;
        cycle(s);
        s = idle(); s.d_valid = 1; s.d_rs = 10; s.use_rs = 1;
        cycle(s);
        s.resetn = 1'b0;
        cycle(s);
        cycle(idle());
        s = idle(); s.l_done = 1; s.l_rn = 10; cycle(s);
        cycle(idle());

        for (int n = 0; n < 1500; n++) rand_cycle();
        cycle(idle());

        repeat (3) @(posedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
